// File: rtl/cla8_seq_adder_ctrl_pkg.sv
// Shared definitions for the sequential CLA add/sub controller:
// FSM state encodings and a counter-width helper.
package cla8_seq_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Slice counter width: clog2(n), never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla8_seq_adder_ctrl_cla.sv
// Carry_lookahead_adder_8bit: combinational 8-bit carry-lookahead adder.
// Ports: a, b (8-bit operands), cin (carry in), sum (8-bit), cout (carry out).
module Carry_lookahead_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of products of generate/propagate
    // terms rather than a ripple chain.
    always_comb begin
        logic cc;
        logic pp;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            cc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & cin);
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/cla8_seq_adder_ctrl.sv
// Multi-cycle W-bit add/sub built from one shared 8-bit CLA, one byte per
// cycle LSB first. Ports: clk, rst_n (sync, active-low), in_valid/in_ready,
// a, b, sub, flush, out_valid/out_ready, result, cout, ovf, zero.
module cla8_seq_adder_ctrl
    import cla8_seq_adder_ctrl_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NSLICE-1:0]   a,
    input  logic [8*NSLICE-1:0]   b,
    input  logic                  sub,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NSLICE-1:0]   result,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero
);

    localparam int W  = 8 * NSLICE;
    localparam int CW = cnt_width(NSLICE);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_eff;
    logic          carry;

    logic [7:0]    a_sl;
    logic [7:0]    b_sl;
    logic [7:0]    sum;
    logic          co;
    logic [W-1:0]  res_nxt;
    logic          last;

    // Select the active byte and build the result as it will look after
    // this edge, so the flags can see the complete word on the last slice.
    always_comb begin
        a_sl    = '0;
        b_sl    = '0;
        res_nxt = result;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt == CW'(i)) begin
                a_sl               = a_reg[8*i +: 8];
                b_sl               = b_eff[8*i +: 8];
                res_nxt[8*i +: 8]  = sum;
            end
        end
    end

    assign last = (cnt == CW'(NSLICE - 1));

    Carry_lookahead_adder_8bit u_cla (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (sum),
        .cout (co)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_reg  <= '0;
            b_eff  <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // flush also blocks an accept while idle
                    if (in_valid && !flush) begin
                        a_reg <= a;
                        b_eff <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        result <= res_nxt;
                        carry  <= co;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            cnt   <= '0;
                            cout  <= co;
                            zero  <= (res_nxt == '0);
                            ovf   <= (a_reg[W-1] == b_eff[W-1]) &&
                                     (res_nxt[W-1] != a_reg[W-1]);
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla8_seq_adder_ctrl.sv
// Self-checking bench for cla8_seq_adder_ctrl: directed steps plus random
// add/sub ops compared against a signed/unsigned arithmetic reference model.
module tb_cla8_seq_adder_ctrl;

    localparam int NSLICE = 4;
    localparam int W      = 8 * NSLICE;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] er;
    logic         ec;
    logic         eo;
    logic         ez;

    cla8_seq_adder_ctrl #(.NSLICE(NSLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic ms);
        longint sa;
        longint sb;
        longint sr;
        logic [W:0] u;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            u  = {1'b0, ma} - {1'b0, mb};
            ec = (ma >= mb);
            sr = sa - sb;
        end else begin
            u  = {1'b0, ma} + {1'b0, mb};
            ec = u[W];
            sr = sa + sb;
        end
        er = u[W-1:0];
        eo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        ez = (er == '0);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive an op at a negedge; returns at the negedge after the accept.
    task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                            input logic os);
        a = oa;
        b = ob;
        sub = os;
        in_valid = 1'b1;
        model(oa, ob, os);
        @(negedge clk);
        chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
    endtask

    task automatic wait_done(input bit keep);
        int k;
        if (!keep) begin
            in_valid = 1'b0;
        end else begin
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
        end
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), 64'(NSLICE));
        chk("result", {32'd0, result}, {32'd0, er});
        chk("cout", {63'd0, cout}, {63'd0, ec});
        chk("ovf", {63'd0, ovf}, {63'd0, eo});
        chk("zero", {63'd0, zero}, {63'd0, ez});
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic os, input bit keep);
        start_op(oa, ob, os);
        wait_done(keep);
        release_op();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // prime result with a nonzero value, then reset mid-CALC
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        start_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'd5, 32'd5, 1'b1, 1'b0);
        run_op(32'd0, 32'd1, 1'b1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0);

        // backpressure
        start_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
        wait_done(1'b0);
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result", {32'd0, result}, {32'd0, er});
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        a = 32'hCAFE_F00D;
        b = 32'h0000_F00E;
        sub = 1'b1;
        in_valid = 1'b1;
        model(a, b, sub);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_idle_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("bp_accept", {63'd0, in_ready}, 64'd0);
        wait_done(1'b0);
        release_op();

        // flush in CALC at cnt=2
        start_op(32'h0000_0003, 32'h0000_0004, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (6) begin
            chk("flush_no_valid", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end

        // flush with in_valid while idle: no accept
        a = 32'h1;
        b = 32'h2;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle", {63'd0, in_ready}, 64'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle2", {63'd0, in_ready}, 64'd1);

        // flush in DONE beats out_ready
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_done(1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done_ready", {63'd0, in_ready}, 64'd1);

        // random, some with in_valid held high back-to-back
        for (int i = 0; i < 60; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                   (i < 59) ? bit'($urandom_range(0, 1)) : 1'b0);
        end
        in_valid = 1'b0;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
